man_demod: RTL and testbench

- Manchester decoder for the RFID card-to-reader path. It is the receive-side counterpart of the team's Manchester encoder.
- Input is the demodulated subcarrier envelope: 1 means the subcarrier is present in that half-bit.
- Output is a decoded bit stream with a one-clock valid strobe, plus start-of-frame, end-of-frame and error flags.
- Runs on the fc/4 clock (3.39 MHz). At 106 kb/s one ETU is 32 clocks.

---
 rtl/man_demod_pkg.sv | 21 ++
 rtl/man_sync.sv | 31 +++
 rtl/man_demod.sv | 127 ++++++++++++
 tb/tb_man_demod.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/man_demod_pkg.sv
// Shared constants and state encoding for the Manchester demodulator.
// HALF/ETU are also used by the matching Manchester encoder.
package man_demod_pkg;

  localparam int N_DEF = 4;
  localparam int HALF  = 1 << N_DEF;
  localparam int ETU   = 2 * HALF;
  localparam int Q1    = HALF / 2;
  localparam int Q3    = HALF + HALF / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOF  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  function automatic int half_len(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/man_sync.sv
// Two-flop synchronizer for the envelope line plus rise/fall detection
// against the previous synchronized value. All flops on the falling clock edge.
module man_sync (
  input  logic clk,
  input  logic in_rst_n,
  input  logic in_data,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic s_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      meta   <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      meta   <= in_data;
      s      <= meta;
      s_prev <= s;
    end
  end

  assign rise = s & ~s_prev;
  assign fall = ~s & s_prev;

endmodule

// File: rtl/man_demod.sv
// Manchester decoder for the card-to-reader path: samples each half-bit at its
// midpoint and decides at the second sample. Optional mid-bit resync: MAN_DEMOD_RESYNC_EN.
module man_demod
  import man_demod_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clk,
  input  logic in_rst_n,
  input  logic in_enable,
  input  logic in_data,
  output logic out_data,
  output logic out_valid,
  output logic out_sof,
  output logic out_eof,
  output logic out_err,
  output logic out_active
);

  localparam int W = N + 1;
  localparam logic [W-1:0] HALF_C = W'(half_len(N));
  localparam logic [W-1:0] Q1_C   = W'(half_len(N) / 2);
  localparam logic [W-1:0] Q3_C   = W'(half_len(N) + half_len(N) / 2);
  localparam logic [W-1:0] WIN_LO = W'(half_len(N) - half_len(N) / 4);
  localparam logic [W-1:0] WIN_HI = W'(half_len(N) + half_len(N) / 4);
`ifdef MAN_DEMOD_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  state_e         state, state_nx;
  logic [W-1:0]   cnt, cnt_nx;
  logic           a, a_nx;
  logic           s, rise, fall;
  logic           decide;
  logic           data_nx, valid_nx, sof_nx, eof_nx, err_nx;

  man_sync u_sync (
    .clk      (clk),
    .in_rst_n (in_rst_n),
    .in_data  (in_data),
    .s        (s),
    .rise     (rise),
    .fall     (fall)
  );

  // The second-half sample b is the live synchronized value s at Q3.
  assign decide = (state != ST_IDLE) && (cnt == Q3_C);

  always_ff @(negedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      a     <= a_nx;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    if (!in_enable) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (rise)   state_nx = ST_SOF;
        ST_SOF:  if (decide) state_nx = (a && !s) ? ST_DATA : ST_IDLE;
        ST_DATA: if (decide && (a == s)) state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Bit timing: counter parks at 0 in IDLE and restarts at 1 on the SOF edge.
  always_comb begin
    cnt_nx = cnt + 1'b1;
    a_nx   = (cnt == Q1_C) ? s : a;
    if (state_nx == ST_IDLE) begin
      cnt_nx = '0;
    end else if (state == ST_IDLE) begin
      cnt_nx = W'(1);
    end else if (RESYNC && (rise || fall) && (cnt >= WIN_LO) && (cnt < WIN_HI)) begin
      cnt_nx = HALF_C;
    end
  end

  always_comb begin
    data_nx  = 1'b0;
    valid_nx = 1'b0;
    sof_nx   = 1'b0;
    eof_nx   = 1'b0;
    err_nx   = 1'b0;
    if (in_enable && decide) begin
      if (state == ST_SOF) begin
        sof_nx = a & ~s;
      end else begin
        valid_nx = a ^ s;
        data_nx  = a & ~s;
        eof_nx   = ~a & ~s;
        err_nx   = a & s;
      end
    end
  end

  always_ff @(negedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_data  <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_data  <= data_nx;
      out_valid <= valid_nx;
      out_sof   <= sof_nx;
      out_eof   <= eof_nx;
      out_err   <= err_nx;
    end
  end

  assign out_active = (state != ST_IDLE);

endmodule

// File: tb/tb_man_demod.sv
// Directed self-checking bench for man_demod (N=4: HALF=16, ETU=32).
// Inputs change and outputs are sampled 1 ns after posedge; the DUT acts on negedge.
module tb_man_demod;

  logic clk       = 1'b0;
  logic in_rst_n  = 1'b1;
  logic in_enable = 1'b1;
  logic in_data   = 1'b0;
  logic out_data, out_valid, out_sof, out_eof, out_err, out_active;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  int n_valid = 0, n_sof = 0, n_eof = 0, n_err = 0, n_multi = 0;
  int valid_t[$];
  logic valid_d[$];
  logic prev_eof = 1'b0, prev_active = 1'b0;
  logic act_before_eof = 1'b0, act_after_eof = 1'b1;

  man_demod #(.N(4)) dut (
    .clk        (clk),
    .in_rst_n   (in_rst_n),
    .in_enable  (in_enable),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_err    (out_err),
    .out_active (out_active)
  );

  always #5 clk = ~clk;

  // Event log of everything the DUT emits.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid === 1'b1) begin
      valid_t.push_back(cyc);
      valid_d.push_back(out_data);
    end
    n_valid <= n_valid + int'(out_valid === 1'b1);
    n_sof   <= n_sof   + int'(out_sof === 1'b1);
    n_eof   <= n_eof   + int'(out_eof === 1'b1);
    n_err   <= n_err   + int'(out_err === 1'b1);
    if ((int'(out_valid === 1'b1) + int'(out_sof === 1'b1) +
         int'(out_eof === 1'b1) + int'(out_err === 1'b1)) > 1)
      n_multi <= n_multi + 1;
    if (out_eof === 1'b1) act_before_eof <= prev_active;
    if (prev_eof === 1'b1) act_after_eof <= out_active;
    prev_eof    <= out_eof;
    prev_active <= out_active;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half(input logic v, input int len);
    in_data = v;
    repeat (len) tick();
  endtask

  task automatic mbit(input logic v, input int l1, input int l2);
    half(v, l1);
    half(!v, l2);
  endtask

  task automatic wait_inactive(input string tag, input int max_cyc);
    int k = 0;
    while (out_active !== 1'b0 && k < max_cyc) begin
      tick();
      k++;
    end
    check(tag, {31'd0, out_active}, 32'd0);
  endtask

  function automatic logic [15:0] rx_bits(input int base, input int n);
    logic [15:0] w = '0;
    for (int i = 0; i < n; i++)
      w = {w[14:0], (base + i < valid_d.size()) ? valid_d[base + i] : 1'b0};
    return w;
  endfunction

  initial begin
    int qb, v0, s0, e0, r0, v_dis;
    logic [15:0] word, pat;
    logic mism;

    // Reset with the line toggling: everything stays 0.
    #1 in_rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = i[0];
      tick();
    end
    check("rst_outs", {26'd0, out_data, out_valid, out_sof, out_eof, out_err, out_active}, 32'd0);
    in_data = 1'b1;
    tick();
    check("rst_active", {31'd0, out_active}, 32'd0);
    in_data = 1'b0;
    repeat (3) tick();
    in_rst_n = 1'b1;
    repeat (10) tick();
    check("post_rst_idle", {26'd0, out_data, out_valid, out_sof, out_eof, out_err, out_active}, 32'd0);

    // Frame: start, 1,0,1,1, then idle low.
    qb = valid_t.size(); v0 = n_valid; s0 = n_sof; e0 = n_eof; r0 = n_err;
    mbit(1'b1, 16, 16);
    mbit(1'b1, 16, 16);
    mbit(1'b0, 16, 16);
    mbit(1'b1, 16, 16);
    mbit(1'b1, 16, 16);
    in_data = 1'b0;
    wait_inactive("frame_end", 100);
    repeat (4) tick();
    check("frame_sof", n_sof - s0, 1);
    check("frame_nvalid", n_valid - v0, 4);
    check("frame_bits", {28'd0, rx_bits(qb, 4)}, 32'hB);
    if (valid_t.size() >= qb + 4)
      for (int i = 0; i < 3; i++)
        check("frame_spacing", valid_t[qb + i + 1] - valid_t[qb + i], 32);
    check("frame_eof", n_eof - e0, 1);
    check("frame_err", n_err - r0, 0);
    check("frame_act_before_eof", {31'd0, act_before_eof}, 32'd1);
    check("frame_act_after_eof", {31'd0, act_after_eof}, 32'd0);
    repeat (10) tick();

    // Violation: start, data 0, then a (1,1) half-bit pair.
    qb = valid_t.size(); v0 = n_valid; s0 = n_sof; e0 = n_eof; r0 = n_err;
    mbit(1'b1, 16, 16);
    mbit(1'b0, 16, 16);
    half(1'b1, 32);
    in_data = 1'b0;
    wait_inactive("viol_end", 100);
    repeat (40) tick();
    check("viol_sof", n_sof - s0, 1);
    check("viol_nvalid", n_valid - v0, 1);
    check("viol_bit", {31'd0, rx_bits(qb, 1)}, 32'd0);
    check("viol_err", n_err - r0, 1);
    check("viol_eof", n_eof - e0, 0);
    check("viol_idle", {31'd0, out_active}, 32'd0);

    // Glitch: 3-clock pulse while idle is rejected silently.
    v0 = n_valid; s0 = n_sof; e0 = n_eof; r0 = n_err;
    half(1'b1, 3);
    half(1'b0, 10);
    check("glitch_active", {31'd0, out_active}, 32'd1);
    repeat (40) tick();
    check("glitch_idle", {31'd0, out_active}, 32'd0);
    check("glitch_strobes", (n_valid - v0) + (n_sof - s0) + (n_eof - e0) + (n_err - r0), 0);

    // Drift: 0xA5C3 MSB first with a 33-clock ETU.
    qb = valid_t.size(); v0 = n_valid; e0 = n_eof; r0 = n_err;
    pat = 16'hA5C3;
    mbit(1'b1, 16, 17);
    for (int i = 15; i >= 0; i--) mbit(pat[i], 16, 17);
    in_data = 1'b0;
    wait_inactive("drift_end", 200);
    repeat (10) tick();
    word = rx_bits(qb, 16);
`ifdef MAN_DEMOD_RESYNC_EN
    check("drift_nvalid", n_valid - v0, 16);
    check("drift_word", {16'd0, word}, 32'hA5C3);
    check("drift_eof", n_eof - e0, 1);
    check("drift_err", n_err - r0, 0);
`else
    mism = ((n_valid - v0) != 16) || (word != 16'hA5C3);
    check("drift_mismatch", {31'd0, mism}, 32'd1);
`endif
    repeat (10) tick();

    // Disable after the 2nd data bit.
    qb = valid_t.size(); v0 = n_valid; s0 = n_sof; e0 = n_eof; r0 = n_err;
    mbit(1'b1, 16, 16);
    mbit(1'b1, 16, 16);
    mbit(1'b0, 16, 16);
    in_enable = 1'b0;
    tick();
    check("dis_active", {31'd0, out_active}, 32'd0);
    v_dis = n_valid;
    mbit(1'b1, 16, 16);
    mbit(1'b1, 16, 16);
    half(1'b0, 40);
    check("dis_sof", n_sof - s0, 1);
    check("dis_nvalid", n_valid - v0, 2);
    check("dis_bits", {30'd0, rx_bits(qb, 2)}, 32'h2);
    check("dis_after", n_valid - v_dis, 0);
    check("dis_eof_err", (n_eof - e0) + (n_err - r0), 0);
    in_enable = 1'b1;
    repeat (5) tick();
    check("dis_reenable_idle", {31'd0, out_active}, 32'd0);

    // Asynchronous reset in the middle of a frame.
    mbit(1'b1, 16, 16);
    half(1'b1, 16);
    half(1'b0, 6);
    check("midrst_pre_active", {31'd0, out_active}, 32'd1);
    #2 in_rst_n = 1'b0;
    #1;
    check("midrst_clear", {26'd0, out_data, out_valid, out_sof, out_eof, out_err, out_active}, 32'd0);
    in_data = 1'b0;
    repeat (4) tick();
    in_rst_n = 1'b1;
    repeat (40) tick();
    check("midrst_idle", {31'd0, out_active}, 32'd0);

    check("exclusive_strobes", n_multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
